seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU. Keeps the existing 4-bit alucontrol encodings for logic and arithmetic ops.
- Adds iterative unsigned multiply and divide with a HI/LO result pair, an overflow flag, and a start/busy/done handshake.
- Sits in the multicycle MIPS datapath between the operand registers and the ALUOut/HI/LO registers. The controller stalls on busy.

Parameters:
- WIDTH, 32, operand and result width in bits; legal values 8 to 64.
- CNTW, $clog2(WIDTH)+1, iteration counter width; derived, must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; operands and alucontrol are sampled on the clk edge where start=1 and busy=0.
- srca  input  WIDTH  operand A; dividend for DIV.
- srcb  input  WIDTH  operand B; divisor for DIV.
- alucontrol  input  4  operation select.
- busy  output  1  iterative op in progress; start is ignored while high.
- done  output  1  one-cycle pulse; results valid from this cycle.
- aluout  output  WIDTH  result, or LO half for MUL/DIV.
- hiout  output  WIDTH  MUL high half, or DIV remainder.
- zero  output  1  registered (srca==srcb) of the accepted operands.
- ovf  output  1  signed overflow for ADD/SUB; 0 for all other ops.

Behaviour:
- Reset (reset_n=0, asynchronous): busy=0, done=0, aluout=0, hiout=0, zero=0, ovf=0, FSM to IDLE, counter=0.
- Reset mid-operation aborts the op immediately; no done pulse for the aborted op.
- FSM states:
  - IDLE: start accepted → if MUL/DIV go to ITER, else go to FIN.
  - ITER: counter runs 0..WIDTH-1, one shift-add or restore step per cycle; after step WIDTH-1 go to FIN.
  - FIN: done=1 for exactly one cycle. A new start is accepted in FIN (back-to-back); otherwise return to IDLE.
- Single-cycle ops: start at edge E → results and done=1 after E+1. Latency 1, throughput 1 per 2 cycles, or 1 per cycle using the FIN acceptance.
- MUL/DIV: start at edge E → busy=1 after edges E+1 .. E+WIDTH, done=1 after edge E+WIDTH+1. busy=0 in the done cycle.
- Op encodings (all arithmetic mod 2^WIDTH):
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR.
  - 0111 SLT: signed compare srca<srcb → aluout = 1 or 0. Overflow-correct: sign of diff XOR overflow.
  - 1000 MULU: {hiout,aluout} = srca*srcb, unsigned 2·WIDTH product, shift-add.
  - 1001 DIVU: aluout = quotient, hiout = remainder; restoring division.
- hiout changes only on MUL/DIV completion; it holds across all other ops.
- ovf: ADD = operands same sign and result sign differs; SUB = operands differ in sign and result sign differs from srca.
- DIVU with srcb=0: no iteration; FIN the cycle after accept; aluout = all ones, hiout = srca, ovf=0.
- Undefined alucontrol: aluout=0, ovf=0, hiout held, done after 1 cycle. No latch.
- start while busy=1: ignored, no queuing. Inputs need be stable only at the accept edge.
- Outputs hold their last values between done pulses.

Optional Feature:
- Macro SEQ_ALU_SIGNED_MULDIV_EN.
- Defined: adds 1010 MUL (signed) and 1011 DIV (signed).
  - Operands are converted to magnitude at accept; the unsigned core is reused; results are sign-corrected in FIN. Same latency.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign.
  - Most-negative / -1: aluout = most-negative, hiout = 0, ovf=1.
  - Divide by zero: same as DIVU.
- Not defined: 1010 and 1011 behave as undefined codes.

Test Plan:
- Reset, then ADD 0x7FFFFFFF+1 → done after 1 cycle, aluout=0x80000000, ovf=1, zero=0; SUB 3-3 → aluout=0, zero=1, ovf=0.
- SLT srca=3, srcb=0xFFFFFFFA (-6) → aluout=0. SLT srca=0x80000000, srcb=1 → aluout=1. AND/OR/NOR on 3,-6 → 0x2 / 0xFFFFFFFB / 0x4.
- MULU 0xFFFFFFFF*0xFFFFFFFF → busy for 32 cycles, done at cycle 33, hiout=0xFFFFFFFE, aluout=0x00000001. start pulses during busy are ignored.
- DIVU 100/7 → aluout=14, hiout=2 at cycle 33. DIVU 5/0 → done at cycle 1, aluout=0xFFFFFFFF, hiout=5.
- Reset_n low at ITER cycle 10 of a MULU → all outputs 0 immediately, no done. Back-to-back ADD accepted in the FIN cycle of the previous op → done on consecutive cycles.
- WIDTH=8, with SEQ_ALU_SIGNED_MULDIV_EN: DIV -7/2 → aluout=0xFD, hiout=0xFF. DIV 0x80/0xFF → aluout=0x80, ovf=1. MUL -3*5 → {hiout,aluout}=0xFFF1, done at cycle 9.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with iterative unsigned multiply/divide.
//
// Purpose:
//   The single-cycle ops (AND, OR, ADD, SUB, NOR, SLT) complete one cycle
//   after they are accepted. MULU (shift-add) and DIVU (restoring) take
//   WIDTH iteration cycles and produce a HI/LO result pair.
//   The op and operands are accepted on a clk edge where start=1 and busy=0.
//   Acceptance is also possible in the done cycle, which allows back-to-back ops.
//
// Optional feature:
//   Define SEQ_ALU_SIGNED_MULDIV_EN to add signed MUL (1010) and DIV (1011).
//   Operands are converted to magnitudes when the op is accepted. The same
//   unsigned core then runs, and the results are sign-corrected on completion.
//   In the default build, 1010 and 1011 act as undefined codes.
//
// Parameters:
//   WIDTH  operand/result width (8..64)
//   CNTW   iteration counter width; derived, leave at default
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   start       request; sampled together with operands when busy=0
//   srca, srcb  operands (dividend / divisor for DIV)
//   alucontrol  operation select
//   busy        iterative op in progress; start ignored while high
//   done        one-cycle pulse; results valid from this cycle
//   aluout      result, or LO half / quotient
//   hiout       MUL high half or DIV remainder; held across other ops
//   zero        registered srca==srcb of the accepted operands
//   ovf         signed overflow for ADD/SUB (and signed DIV MIN/-1)
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       alucontrol,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] aluout,
  output logic [WIDTH-1:0] hiout,
  output logic             zero,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic [CNTW-1:0]    cnt;
  logic [WIDTH-1:0]   ahi, alo, opb;
  logic               op_div, neg_q, neg_r, ovf_pend, zero_pend;

  logic               accept, last, iter_op, div_zero;
  logic               is_mul, is_div, is_sgn;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   sum, diff, alu_res;
  logic               add_ovf, sub_ovf, alu_ovf;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   step_hi, step_lo, fin_hi, fin_lo;
  logic [2*WIDTH-1:0] prod;

  assign busy   = (state == ITER);
  assign done   = (state == FIN);
  assign accept = start && (state != ITER);
  assign last   = (cnt == CNTW'(WIDTH - 1));

  always_comb begin : decode
    is_mul = 1'b0;
    is_div = 1'b0;
    is_sgn = 1'b0;
    case (alucontrol)
      4'b1000: is_mul = 1'b1;
      4'b1001: is_div = 1'b1;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
      4'b1010: begin is_mul = 1'b1; is_sgn = 1'b1; end
      4'b1011: begin is_div = 1'b1; is_sgn = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign div_zero = is_div && (srcb == '0);
  assign iter_op  = (is_mul || is_div) && !div_zero;
  assign a_neg    = is_sgn && srca[WIDTH-1];
  assign b_neg    = is_sgn && srcb[WIDTH-1];
  assign a_mag    = a_neg ? ('0 - srca) : srca;
  assign b_mag    = b_neg ? ('0 - srcb) : srcb;

  // Single-cycle datapath
  assign sum     = srca + srcb;
  assign diff    = srca - srcb;
  assign add_ovf = (srca[WIDTH-1] == srcb[WIDTH-1]) && (sum[WIDTH-1] != srca[WIDTH-1]);
  assign sub_ovf = (srca[WIDTH-1] != srcb[WIDTH-1]) && (diff[WIDTH-1] != srca[WIDTH-1]);

  always_comb begin : single_cycle
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alucontrol)
      4'b0000: alu_res = srca & srcb;
      4'b0001: alu_res = srca | srcb;
      4'b0010: begin alu_res = sum;  alu_ovf = add_ovf; end
      4'b0110: begin alu_res = diff; alu_ovf = sub_ovf; end
      4'b1100: alu_res = ~(srca | srcb);
      // The diff sign is corrected by the overflow bit, so SLT stays right
      // even when the subtraction wraps.
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
      default: ;
    endcase
  end

  // One iteration step. MUL shifts {ahi,alo} right after a conditional add.
  // DIV shifts {ahi,alo} left and subtracts the divisor when it fits, so
  // alo ends up holding the quotient and ahi the remainder.
  assign mul_sum   = {1'b0, ahi} + (alo[0] ? {1'b0, opb} : '0);
  assign div_shift = {ahi, alo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opb});

  always_comb begin : iter_step
    if (op_div) begin
      step_hi = div_ge ? (div_shift[WIDTH-1:0] - opb) : div_shift[WIDTH-1:0];
      step_lo = {alo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], alo[WIDTH-1:1]};
    end
  end

  always_comb begin : sign_fix
    prod   = {step_hi, step_lo};
    fin_lo = step_lo;
    fin_hi = step_hi;
    if (op_div) begin
      if (neg_q) fin_lo = '0 - step_lo;
      if (neg_r) fin_hi = '0 - step_hi;
    end else begin
      if (neg_q) prod = '0 - prod;
      fin_lo = prod[WIDTH-1:0];
      fin_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin : next_state
    state_nxt = state;
    case (state)
      ITER: if (last) state_nxt = FIN;
      FIN:  if (accept) state_nxt = iter_op ? ITER : FIN;
            else        state_nxt = IDLE;
      default: if (accept) state_nxt = iter_op ? ITER : FIN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      ahi       <= '0;
      alo       <= '0;
      opb       <= '0;
      op_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      ovf_pend  <= 1'b0;
      zero_pend <= 1'b0;
      aluout    <= '0;
      hiout     <= '0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else if (state == ITER) begin
      ahi <= step_hi;
      alo <= step_lo;
      if (last) begin
        cnt    <= '0;
        aluout <= fin_lo;
        hiout  <= fin_hi;
        ovf    <= ovf_pend;
        zero   <= zero_pend;
      end else begin
        cnt <= cnt + CNTW'(1);
      end
    end else if (accept) begin
      if (iter_op) begin
        // Results are published only on completion, so the flags wait here.
        cnt       <= '0;
        op_div    <= is_div;
        ahi       <= '0;
        alo       <= is_div ? a_mag : b_mag;
        opb       <= is_div ? b_mag : a_mag;
        neg_q     <= a_neg ^ b_neg;
        neg_r     <= a_neg;
        ovf_pend  <= is_sgn && is_div && (srca == MOST_NEG) && (srcb == '1);
        zero_pend <= (srca == srcb);
      end else if (div_zero) begin
        aluout <= '1;
        hiout  <= srca;
        ovf    <= 1'b0;
        zero   <= (srca == srcb);
      end else begin
        aluout <= alu_res;
        ovf    <= alu_ovf;
        zero   <= (srca == srcb);
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;

  logic        start = 1'b0;
  logic [31:0] srca = '0, srcb = '0;
  logic [3:0]  alucontrol = '0;
  logic        busy, done, zero, ovf;
  logic [31:0] aluout, hiout;

  logic        start8 = 1'b0;
  logic [7:0]  srca8 = '0, srcb8 = '0;
  logic [3:0]  op8 = '0;
  logic        busy8, done8, zero8, ovf8;
  logic [7:0]  aluout8, hiout8;

  int errors = 0;
  int checks = 0;
  logic [31:0] hi32;
  logic [7:0]  hi8;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .srca(srca), .srcb(srcb),
    .alucontrol(alucontrol), .busy(busy), .done(done), .aluout(aluout),
    .hiout(hiout), .zero(zero), .ovf(ovf)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .srca(srca8), .srcb(srcb8),
    .alucontrol(op8), .busy(busy8), .done(done8), .aluout(aluout8),
    .hiout(hiout8), .zero(zero8), .ovf(ovf8)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference models: plain integer arithmetic on the op definitions.
  function automatic void ref32(input logic [3:0] op, input logic [31:0] a, b, hprev,
                                output logic [31:0] r, h, output logic v, output int lat);
    longint sa, sb, s;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    r = '0; h = hprev; v = 1'b0; lat = 1;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'hC: r = ~(a | b);
      4'h2: begin s = sa + sb; r = s[31:0]; v = (longint'($signed(r)) != s); end
      4'h6: begin s = sa - sb; r = s[31:0]; v = (longint'($signed(r)) != s); end
      4'h7: r = (sa < sb) ? 32'd1 : 32'd0;
      4'h8: begin p = 64'(a) * 64'(b); r = p[31:0]; h = p[63:32]; lat = 33; end
      4'h9: if (b == 0) begin r = '1; h = a; end
            else begin r = a / b; h = a % b; lat = 33; end
      default: ;
    endcase
  endfunction

  function automatic void ref8(input logic [3:0] op, input logic [7:0] a, b, hprev,
                               output logic [7:0] r, h, output logic v, output int lat);
    int sa, sb, s, t;
    logic [15:0] p;
    sa = $signed(a);
    sb = $signed(b);
    r = '0; h = hprev; v = 1'b0; lat = 1;
    case (op)
      4'h0: r = a & b;
      4'h1: r = a | b;
      4'hC: r = ~(a | b);
      4'h2: begin s = sa + sb; r = s[7:0]; v = (int'($signed(r)) != s); end
      4'h6: begin s = sa - sb; r = s[7:0]; v = (int'($signed(r)) != s); end
      4'h7: r = (sa < sb) ? 8'd1 : 8'd0;
      4'h8: begin p = 16'(a) * 16'(b); r = p[7:0]; h = p[15:8]; lat = 9; end
      4'h9: if (b == 0) begin r = '1; h = a; end
            else begin r = a / b; h = a % b; lat = 9; end
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
      4'hA: begin s = sa * sb; r = s[7:0]; h = s[15:8]; lat = 9; end
      4'hB: if (b == 0) begin r = '1; h = a; end
            else begin
              s = sa / sb; t = sa % sb;
              r = s[7:0]; h = t[7:0]; v = (s > 127); lat = 9;
            end
`endif
      default: ;
    endcase
  endfunction

  // Issue one op; return in the done cycle (or after the bound expires).
  task automatic issue32(input logic [3:0] op, input logic [31:0] a, b, input bit inject,
                         output int lat, output bit busy_bad);
    @(negedge clk);
    start = 1'b1; alucontrol = op; srca = a; srcb = b;
    @(posedge clk); #1;
    start = 1'b0; srca = $urandom; srcb = $urandom; alucontrol = 4'($urandom);
    lat = 1; busy_bad = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      start = inject ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (busy !== 1'b0) busy_bad = 1'b1;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, b,
                        output int lat, output bit busy_bad);
    @(negedge clk);
    start8 = 1'b1; op8 = op; srca8 = a; srcb8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; srca8 = 8'($urandom); srcb8 = 8'($urandom); op8 = 4'($urandom);
    lat = 1; busy_bad = 1'b0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (busy8 !== 1'b1) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (busy8 !== 1'b0) busy_bad = 1'b1;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #3;
    checks++; if ({busy, done, zero, ovf} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b exp 0000", {busy, done, zero, ovf}); end
    checks++; if (aluout !== '0) begin errors++; $display("FAIL reset_aluout: got %h exp 0", aluout); end
    checks++; if (hiout !== '0) begin errors++; $display("FAIL reset_hiout: got %h exp 0", hiout); end
    checks++; if ({busy8, done8, zero8, ovf8, aluout8, hiout8} !== 20'b0) begin errors++; $display("FAIL reset_w8: got %h exp 0", {busy8, done8, zero8, ovf8, aluout8, hiout8}); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_add_sub();
    int lat; bit bb;
    issue32(4'b0010, 32'h7FFFFFFF, 32'h1, 0, lat, bb);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d exp 1", lat); end
    checks++; if (aluout !== 32'h80000000) begin errors++; $display("FAIL add_res: got %h exp 80000000", aluout); end
    checks++; if ({ovf, zero} !== 2'b10) begin errors++; $display("FAIL add_flags: got ovf,zero=%b exp 10", {ovf, zero}); end
    issue32(4'b0110, 32'd3, 32'd3, 0, lat, bb);
    checks++; if (aluout !== 32'h0) begin errors++; $display("FAIL sub_res: got %h exp 0", aluout); end
    checks++; if ({ovf, zero} !== 2'b01) begin errors++; $display("FAIL sub_flags: got ovf,zero=%b exp 01", {ovf, zero}); end
    issue32(4'b0110, 32'h80000000, 32'h1, 0, lat, bb);
    checks++; if ({aluout, ovf} !== {32'h7FFFFFFF, 1'b1}) begin errors++; $display("FAIL sub_ovf: got %h/%b exp 7fffffff/1", aluout, ovf); end
  endtask

  task automatic test_slt_logic();
    int lat; bit bb;
    issue32(4'b0111, 32'd3, 32'hFFFFFFFA, 0, lat, bb);
    checks++; if (aluout !== 32'd0) begin errors++; $display("FAIL slt_pos_neg: got %h exp 0", aluout); end
    issue32(4'b0111, 32'h80000000, 32'd1, 0, lat, bb);
    checks++; if (aluout !== 32'd1) begin errors++; $display("FAIL slt_min_one: got %h exp 1", aluout); end
    issue32(4'b0000, 32'd3, 32'hFFFFFFFA, 0, lat, bb);
    checks++; if (aluout !== 32'h2) begin errors++; $display("FAIL and: got %h exp 2", aluout); end
    issue32(4'b0001, 32'd3, 32'hFFFFFFFA, 0, lat, bb);
    checks++; if (aluout !== 32'hFFFFFFFB) begin errors++; $display("FAIL or: got %h exp fffffffb", aluout); end
    issue32(4'b1100, 32'd3, 32'hFFFFFFFA, 0, lat, bb);
    checks++; if (aluout !== 32'h4) begin errors++; $display("FAIL nor: got %h exp 4", aluout); end
  endtask

  task automatic test_mulu();
    int lat; bit bb;
    issue32(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, lat, bb);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mulu_latency: got %0d exp 33", lat); end
    checks++; if (bb !== 1'b0) begin errors++; $display("FAIL mulu_busy: got bad=%b exp 0", bb); end
    checks++; if ({hiout, aluout} !== 64'hFFFFFFFE00000001) begin errors++; $display("FAIL mulu_res: got %h%h exp fffffffe00000001", hiout, aluout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL mulu_ovf: got %b exp 0", ovf); end
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL mulu_no_queue: got busy,done=%b exp 00", {busy, done}); end
  endtask

  task automatic test_divu();
    int lat; bit bb;
    issue32(4'b1001, 32'd100, 32'd7, 0, lat, bb);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d exp 33", lat); end
    checks++; if ({aluout, hiout} !== {32'd14, 32'd2}) begin errors++; $display("FAIL divu_res: got q=%0d r=%0d exp 14/2", aluout, hiout); end
    issue32(4'b1001, 32'd5, 32'd0, 0, lat, bb);
    checks++; if (lat !== 1) begin errors++; $display("FAIL div0_latency: got %0d exp 1", lat); end
    checks++; if ({aluout, hiout, ovf} !== {32'hFFFFFFFF, 32'd5, 1'b0}) begin errors++; $display("FAIL div0_res: got %h/%h/%b exp ffffffff/5/0", aluout, hiout, ovf); end
    issue32(4'b0010, 32'd1, 32'd1, 0, lat, bb);
    checks++; if ({aluout, hiout} !== {32'd2, 32'd5}) begin errors++; $display("FAIL hi_hold: got %h/%h exp 2/5", aluout, hiout); end
  endtask

  task automatic test_undefined();
    int lat; bit bb;
    issue32(4'b0011, 32'h12345678, 32'h9ABCDEF0, 0, lat, bb);
    checks++; if ({lat == 1, aluout, ovf, hiout} !== {1'b1, 32'd0, 1'b0, 32'd5}) begin errors++; $display("FAIL undef_op: got lat=%0d %h/%b/%h exp 1 0/0/5", lat, aluout, ovf, hiout); end
  endtask

  task automatic test_back_to_back();
    int lat; bit bb;
    @(negedge clk);
    start = 1'b1; alucontrol = 4'b0010; srca = 32'd1; srcb = 32'd2;
    @(posedge clk); #1;
    checks++; if ({done, aluout} !== {1'b1, 32'd3}) begin errors++; $display("FAIL b2b_first: got %b/%h exp 1/3", done, aluout); end
    srca = 32'd10; srcb = 32'd20;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if ({done, aluout} !== {1'b1, 32'd30}) begin errors++; $display("FAIL b2b_second: got %b/%h exp 1/1e", done, aluout); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_pulse: got %b exp 0", done); end
    issue32(4'b1000, 32'd6, 32'd7, 0, lat, bb);
    checks++; if ({aluout, hiout} !== {32'd42, 32'd0}) begin errors++; $display("FAIL b2b_mul: got %h/%h exp 2a/0", aluout, hiout); end
    start = 1'b1; alucontrol = 4'b0010; srca = 32'd5; srcb = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if ({done, aluout, zero} !== {1'b1, 32'd10, 1'b1}) begin errors++; $display("FAIL b2b_after_mul: got %b/%h/%b exp 1/a/1", done, aluout, zero); end
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    start = 1'b1; alucontrol = 4'b1000; srca = $urandom | 32'h1; srcb = $urandom | 32'h1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({busy, done, zero, ovf, aluout, hiout} !== 68'b0) begin errors++; $display("FAIL abort_outputs: got %b%b%b%b %h %h exp all 0", busy, done, zero, ovf, aluout, hiout); end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles exp 0", seen); end
  endtask

  task automatic test_random32();
    logic [3:0] ops[10] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'hC, 4'h7, 4'h8, 4'h9, 4'h3, 4'hF};
    logic [3:0] op; logic [31:0] a, b, er, eh; logic ev; int el, lat; bit bb;
    for (int unsigned i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 9)];
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = a;
        2: b = $urandom_range(1, 255);
        default: ;
      endcase
      if (i == 0) begin op = 4'h9; b = '0; end
      ref32(op, a, b, hi32, er, eh, ev, el);
      issue32(op, a, b, 0, lat, bb);
      hi32 = eh;
      checks++; if (lat !== el) begin errors++; $display("FAIL rnd32_lat op=%h: got %0d exp %0d", op, lat, el); end
      checks++; if (aluout !== er) begin errors++; $display("FAIL rnd32_res op=%h a=%h b=%h: got %h exp %h", op, a, b, aluout, er); end
      checks++; if (hiout !== eh) begin errors++; $display("FAIL rnd32_hi op=%h a=%h b=%h: got %h exp %h", op, a, b, hiout, eh); end
      checks++; if ({zero, ovf} !== {a == b, ev}) begin errors++; $display("FAIL rnd32_flags op=%h: got %b exp %b", op, {zero, ovf}, {a == b, ev}); end
      checks++; if (bb !== 1'b0) begin errors++; $display("FAIL rnd32_busy op=%h: got bad=1 exp 0", op); end
    end
  endtask

  task automatic test_signed8();
    int lat; bit bb;
`ifdef SEQ_ALU_SIGNED_MULDIV_EN
    issue8(4'b1011, 8'hF9, 8'h02, lat, bb);
    checks++; if ({lat == 9, aluout8, hiout8, ovf8} !== {1'b1, 8'hFD, 8'hFF, 1'b0}) begin errors++; $display("FAIL sdiv_m7_2: got lat=%0d %h/%h/%b exp 9 fd/ff/0", lat, aluout8, hiout8, ovf8); end
    issue8(4'b1011, 8'h80, 8'hFF, lat, bb);
    checks++; if ({aluout8, hiout8, ovf8} !== {8'h80, 8'h00, 1'b1}) begin errors++; $display("FAIL sdiv_min_m1: got %h/%h/%b exp 80/00/1", aluout8, hiout8, ovf8); end
    issue8(4'b1010, 8'hFD, 8'h05, lat, bb);
    checks++; if ({lat == 9, hiout8, aluout8} !== {1'b1, 16'hFFF1}) begin errors++; $display("FAIL smul_m3_5: got lat=%0d %h%h exp 9 fff1", lat, hiout8, aluout8); end
`else
    issue8(4'b1001, 8'h2A, 8'h00, lat, bb);
    issue8(4'b1010, 8'hFD, 8'h05, lat, bb);
    checks++; if ({lat == 1, aluout8, hiout8, ovf8} !== {1'b1, 8'h00, 8'h2A, 1'b0}) begin errors++; $display("FAIL smul_undef: got lat=%0d %h/%h/%b exp 1 00/2a/0", lat, aluout8, hiout8, ovf8); end
    issue8(4'b1011, 8'hF9, 8'h02, lat, bb);
    checks++; if ({lat == 1, aluout8, hiout8} !== {1'b1, 8'h00, 8'h2A}) begin errors++; $display("FAIL sdiv_undef: got lat=%0d %h/%h exp 1 00/2a", lat, aluout8, hiout8); end
`endif
  endtask

  task automatic test_random8();
    logic [3:0] ops[10] = '{4'h0, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hA, 4'hB};
    logic [3:0] op; logic [7:0] a, b, er, eh; logic ev; int el, lat; bit bb;
    for (int unsigned i = 0; i < 30; i++) begin
      op = ops[$urandom_range(0, 9)];
      a = 8'($urandom); b = 8'($urandom);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = a;
        2: begin a = 8'h80; b = 8'hFF; end
        default: ;
      endcase
      if (i == 0) begin op = 4'h9; b = '0; end
      ref8(op, a, b, hi8, er, eh, ev, el);
      issue8(op, a, b, lat, bb);
      hi8 = eh;
      checks++; if (lat !== el) begin errors++; $display("FAIL rnd8_lat op=%h: got %0d exp %0d", op, lat, el); end
      checks++; if ({aluout8, hiout8} !== {er, eh}) begin errors++; $display("FAIL rnd8_res op=%h a=%h b=%h: got %h/%h exp %h/%h", op, a, b, aluout8, hiout8, er, eh); end
      checks++; if ({zero8, ovf8, bb} !== {a == b, ev, 1'b0}) begin errors++; $display("FAIL rnd8_flags op=%h a=%h b=%h: got %b exp %b", op, a, b, {zero8, ovf8, bb}, {a == b, ev, 1'b0}); end
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_slt_logic();
    test_mulu();
    test_divu();
    test_undefined();
    test_back_to_back();
    test_abort();
    test_random32();
    test_signed8();
    test_random8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
